// File: rtl/vc_arbiter.sv
// =============================================================================
// Module      : vc_arbiter
// Description : Weighted round-robin drain of two VC FIFOs into one downstream
//               FIFO with downstream backpressure and a 2-stage write pipeline.
//               Optional macro VC_ARB_STRICT_PRIO_EN selects strict VC0 priority.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module vc_arbiter #(
    parameter int BW    = 6,
    parameter int CNT_W = 4,
    parameter int W0    = 3,
    parameter int W1    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] vc0_data_in,
    input  logic          vc0_empty,
    input  logic [BW-1:0] vc1_data_in,
    input  logic          vc1_empty,
    input  logic          out_almost_full,
    input  logic          out_full,
    output logic          vc0_rd,
    output logic          vc1_rd,
    output logic [BW-1:0] out_data,
    output logic          out_wr,
    output logic          idle
);

    typedef enum logic [0:0] {
        SERVE0 = 1'b0,
        SERVE1 = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sel;
    logic             r_pend;
    logic             w_pause;
    logic             w_pop0;
    logic             w_pop1;

    assign w_pause = out_almost_full | out_full;

`ifdef VC_ARB_STRICT_PRIO_EN
    // Strict priority: weights unused, counter parked at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_pop0      = 1'b0;
        w_pop1      = 1'b0;
        if (!w_pause) begin
            if (!vc0_empty) begin
                w_pop0      = 1'b1;
                w_state_nxt = SERVE0;
            end else if (!vc1_empty) begin
                w_pop1      = 1'b1;
                w_state_nxt = SERVE1;
            end
        end
    end
`else
    localparam logic [CNT_W-1:0] c_W0 = CNT_W'(W0);
    localparam logic [CNT_W-1:0] c_W1 = CNT_W'(W1);

    logic             w_cur_empty;
    logic             w_oth_empty;
    logic [CNT_W-1:0] w_wcur;
    logic             w_take_cur;
    logic             w_take_oth;

    assign w_cur_empty = (r_state == SERVE0) ? vc0_empty : vc1_empty;
    assign w_oth_empty = (r_state == SERVE0) ? vc1_empty : vc0_empty;
    assign w_wcur      = (r_state == SERVE0) ? c_W0 : c_W1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take_cur  = 1'b0;
        w_take_oth  = 1'b0;
        if (!w_pause) begin
            if (!w_cur_empty && (r_cnt < w_wcur)) begin
                w_take_cur = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
            end else if (!w_oth_empty) begin
                w_take_oth  = 1'b1;
                w_state_nxt = state_t'(~r_state);
                w_cnt_nxt   = CNT_W'(1);
            end else if (!w_cur_empty) begin
                // Lone backlogged VC keeps the turn; quota stays exhausted.
                w_take_cur = 1'b1;
                w_cnt_nxt  = w_wcur;
            end
        end
    end

    assign w_pop0 = (r_state == SERVE0) ? w_take_cur : w_take_oth;
    assign w_pop1 = (r_state == SERVE0) ? w_take_oth : w_take_cur;
`endif

    assign vc0_rd = w_pop0 & ~reset;
    assign vc1_rd = w_pop1 & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= SERVE0;
            r_cnt    <= '0;
            r_sel    <= 1'b0;
            r_pend   <= 1'b0;
            out_wr   <= 1'b0;
            out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pop0 | w_pop1;
            if (w_pop0 | w_pop1) begin
                r_sel <= w_pop1;
            end
            // FIFO read data is valid one cycle after the pop.
            out_wr <= r_pend;
            if (r_pend) begin
                out_data <= r_sel ? vc1_data_in : vc0_data_in;
            end
        end
    end

    assign idle = vc0_empty & vc1_empty & ~r_pend & ~out_wr;

endmodule

`default_nettype wire

// File: tb/tb_vc_arbiter.sv
// =============================================================================
// Module      : tb_vc_arbiter
// Description : Self-checking bench for vc_arbiter: FIFO models, grant model,
//               table-driven pop-order vectors and randomized traffic.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_vc_arbiter;

    localparam int BW    = 6;
    localparam int CNT_W = 4;
    localparam int W0    = 3;
    localparam int W1    = 1;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] vc0_data_in;
    logic          vc0_empty;
    logic [BW-1:0] vc1_data_in;
    logic          vc1_empty;
    logic          out_almost_full;
    logic          out_full;
    logic          vc0_rd;
    logic          vc1_rd;
    logic [BW-1:0] out_data;
    logic          out_wr;
    logic          idle;

    vc_arbiter #(.BW(BW), .CNT_W(CNT_W), .W0(W0), .W1(W1)) dut (
        .clk            (clk),
        .reset          (reset),
        .vc0_data_in    (vc0_data_in),
        .vc0_empty      (vc0_empty),
        .vc1_data_in    (vc1_data_in),
        .vc1_empty      (vc1_empty),
        .out_almost_full(out_almost_full),
        .out_full       (out_full),
        .vc0_rd         (vc0_rd),
        .vc1_rd         (vc1_rd),
        .out_data       (out_data),
        .out_wr         (out_wr),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Upstream FIFO models: pointer arrays, read data valid the cycle after rd.
    logic [BW-1:0] mem0 [DEPTH];
    logic [BW-1:0] mem1 [DEPTH];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign vc0_empty = (rd0 == wr0);
    assign vc1_empty = (rd1 == wr1);

    always @(posedge clk) begin
        if (vc0_rd) begin
            vc0_data_in <= mem0[rd0 % DEPTH];
            rd0 <= rd0 + 1;
        end
        if (vc1_rd) begin
            vc1_data_in <= mem1[rd1 % DEPTH];
            rd1 <= rd1 + 1;
        end
    end

    task automatic push0(input logic [BW-1:0] v);
        mem0[wr0 % DEPTH] = v;
        wr0++;
    endtask

    task automatic push1(input logic [BW-1:0] v);
        mem1[wr1 % DEPTH] = v;
        wr1++;
    endtask

    // Reference: the VC holding the turn, grants used in this turn, and a
    // queue of expected writes tagged with the cycle they must appear in.
    int            cyc = 0;
    int            turn = 0;
    int            used = 0;
    int            qdue[$];
    logic [BW-1:0] qdat[$];
    int            pop_log[$];
    int            pop_cyc[$];
    logic [BW-1:0] wlog[$];
    int            wr_count = 0;

    always @(negedge clk) begin
        int            exp_pop;
        int            quota;
        bit            my_e, ot_e, paused, exp_wr, exp_idle;
        logic [BW-1:0] d;
        cyc++;
        if (reset) begin
            chk(!vc0_rd && !vc1_rd, "rst_rd", {vc1_rd, vc0_rd}, 0);
            chk(!out_wr, "rst_out_wr", out_wr, 0);
            chk(out_data == '0, "rst_out_data", out_data, 0);
            qdue.delete();
            qdat.delete();
            turn = 0;
            used = 0;
        end else begin
            paused  = out_almost_full || out_full;
            exp_pop = -1;
            if (!paused) begin
`ifdef VC_ARB_STRICT_PRIO_EN
                if (!vc0_empty) exp_pop = 0;
                else if (!vc1_empty) exp_pop = 1;
`else
                quota = (turn == 0) ? W0 : W1;
                my_e  = (turn == 0) ? vc0_empty : vc1_empty;
                ot_e  = (turn == 0) ? vc1_empty : vc0_empty;
                if (!my_e && used < quota) begin
                    exp_pop = turn;
                    used    = used + 1;
                end else if (!ot_e) begin
                    turn    = 1 - turn;
                    exp_pop = turn;
                    used    = 1;
                end else if (!my_e) begin
                    exp_pop = turn;
                    used    = quota;
                end
`endif
            end
            chk({vc1_rd, vc0_rd} == ((exp_pop < 0) ? 2'b00 : (exp_pop == 0) ? 2'b01 : 2'b10),
                "rd_grant", {vc1_rd, vc0_rd},
                (exp_pop < 0) ? 0 : (exp_pop == 0) ? 1 : 2);

            exp_idle = vc0_empty && vc1_empty && (qdue.size() == 0);
            chk(idle == exp_idle, "idle", idle, exp_idle);

            exp_wr = (qdue.size() > 0) && (qdue[0] == cyc);
            chk(out_wr == exp_wr, "out_wr", out_wr, exp_wr);
            if (exp_wr) begin
                chk(out_data == qdat[0], "out_data", out_data, qdat[0]);
                void'(qdue.pop_front());
                void'(qdat.pop_front());
            end
            if (out_wr) begin
                wlog.push_back(out_data);
                wr_count++;
            end

            if (exp_pop >= 0) begin
                d = (exp_pop == 0) ? mem0[rd0 % DEPTH] : mem1[rd1 % DEPTH];
                qdue.push_back(cyc + 2);
                qdat.push_back(d);
                pop_log.push_back(exp_pop);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset           = 1'b1;
        out_almost_full = 1'b0;
        out_full        = 1'b0;
        wr0             = rd0;
        wr1             = rd1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk); #1;
            if (idle && qdue.size() == 0) done = 1'b1;
        end
        chk(done, nm, done, 1);
    endtask

    typedef struct {
        int          n0;
        int          n1;
        logic [15:0] order;   // bit i = VC id of the i-th pop
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n;
        int w_at_pause;

        reset           = 1'b1;
        out_almost_full = 1'b0;
        out_full        = 1'b0;

        // Reset held with VC0 non-empty.
        push0(6'h3F);
        repeat (2) @(negedge clk);
        #1;
        chk(!vc0_rd && !vc1_rd, "t1_rd_in_reset", {vc1_rd, vc0_rd}, 0);
        chk(!out_wr, "t1_out_wr", out_wr, 0);
        chk(out_data == '0, "t1_out_data", out_data, 0);
        wr0 = rd0;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk); #1;
        chk(idle, "t1_idle", idle, 1);

        tbl[0] = '{n0: 4, n1: 0, order: 16'h0000};
`ifdef VC_ARB_STRICT_PRIO_EN
        tbl[1] = '{n0: 8, n1: 2, order: 16'h0300};
`else
        tbl[1] = '{n0: 8, n1: 2, order: 16'h0088};
`endif
        tbl[2] = '{n0: 0, n1: 3, order: 16'h0007};
        tbl[3] = '{n0: 2, n1: 2, order: 16'h000C};
        tbl[4] = '{n0: 1, n1: 2, order: 16'h0006};

        foreach (tbl[t]) begin
            do_reset();
            pop_log.delete();
            pop_cyc.delete();
            wlog.delete();
            @(posedge clk); #2;
            for (int k = 0; k < tbl[t].n0; k++) push0(BW'(8'h0A + k));
            for (int k = 0; k < tbl[t].n1; k++) push1(BW'(8'h20 + k));
            wait_idle($sformatf("vec%0d_idle_timeout", t));
            n = tbl[t].n0 + tbl[t].n1;
            chk(pop_log.size() == n, $sformatf("vec%0d_pops", t), pop_log.size(), n);
            chk(wlog.size() == n, $sformatf("vec%0d_writes", t), wlog.size(), n);
            for (int i = 0; i < n && i < pop_log.size(); i++) begin
                chk(pop_log[i] == int'(tbl[t].order[i]), $sformatf("vec%0d_order%0d", t, i),
                    pop_log[i], int'(tbl[t].order[i]));
            end
            if (pop_cyc.size() == n && n > 0)
                chk(pop_cyc[n-1] - pop_cyc[0] == n - 1, $sformatf("vec%0d_back_to_back", t),
                    pop_cyc[n-1] - pop_cyc[0], n - 1);
        end

        // Backpressure after the second write.
        do_reset();
        wlog.delete();
        n = wr_count;
        @(posedge clk); #2;
        for (int k = 0; k < 10; k++) push0(BW'(8'h10 + k));
        for (int c = 0; c < 50 && wr_count < n + 2; c++) @(posedge clk);
        #2 out_almost_full = 1'b1;
        w_at_pause = wr_count;
        repeat (6) @(posedge clk);
        chk(wr_count - w_at_pause == 2, "t4_writes_in_pause", wr_count - w_at_pause, 2);
        #2 out_almost_full = 1'b0;
        wait_idle("t4_idle_timeout");
        chk(wlog.size() == 10, "t4_total_writes", wlog.size(), 10);
        for (int k = 0; k < 10 && k < wlog.size(); k++)
            chk(wlog[k] == BW'(8'h10 + k), "t4_data_order", wlog[k], 8'h10 + k);

        // Reset one cycle after a pop: the in-flight word is dropped.
        do_reset();
        wlog.delete();
        @(posedge clk); #2;
        push0(6'h31);
        push0(6'h32);
        push0(6'h33);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        wait_idle("t6_idle_timeout");
        chk(wlog.size() == 2, "t6_writes", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk(wlog[0] == 6'h32, "t6_first_write", wlog[0], 6'h32);
            chk(wlog[1] == 6'h33, "t6_second_write", wlog[1], 6'h33);
        end

        // Randomized traffic and backpressure.
        do_reset();
        n = wr_count;
        w_at_pause = (wr0 - rd0) + (wr1 - rd1);
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(3) == 0) begin push0(BW'($urandom)); w_at_pause++; end
            if ($urandom_range(4) == 0) begin push1(BW'($urandom)); w_at_pause++; end
            if ($urandom_range(7) == 0) out_almost_full = ~out_almost_full;
            out_full = ($urandom_range(15) == 0);
        end
        @(posedge clk); #2;
        out_almost_full = 1'b0;
        out_full        = 1'b0;
        wait_idle("rand_idle_timeout");
        chk(wr_count - n == w_at_pause, "rand_total_writes", wr_count - n, w_at_pause);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Downstream consumer of the two per-virtual-channel FIFOs (VC0, VC1) in the PCIe QoS TC/VC path.
- Drains both FIFOs by weighted round-robin and writes the selected words into a single downstream FIFO.
- Reads stall on the downstream FIFO's almost-full/full flags, so the downstream umbral_alto threshold sets the backpressure point.
- Data passes through unmodified; only arbitration order is added.

Parameters:
BW, 6, data word width (matches FIFO data width)
CNT_W, 4, width of the credit counter
W0, 3, VC0 grants per turn (legal range 1 to 2^CNT_W-1)
W1, 1, VC1 grants per turn (legal range 1 to 2^CNT_W-1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
vc0_data_in  input  BW  VC0 FIFO read data; valid the cycle after vc0_rd
vc0_empty  input  1  VC0 FIFO empty flag
vc1_data_in  input  BW  VC1 FIFO read data; valid the cycle after vc1_rd
vc1_empty  input  1  VC1 FIFO empty flag
out_almost_full  input  1  downstream FIFO almost-full (above umbral_alto)
out_full  input  1  downstream FIFO full
vc0_rd  output  1  pop VC0 FIFO (combinational)
vc1_rd  output  1  pop VC1 FIFO (combinational)
out_data  output  BW  word to downstream FIFO (registered)
out_wr  output  1  downstream FIFO write strobe (registered)
idle  output  1  no pending work and nothing in flight

Behaviour:
- Reset (async, active-high): state=SERVE0, cnt=0, sel_q=0, pend_q=0, out_wr=0, out_data=0; vc0_rd and vc1_rd forced 0 while reset is high.
- Mid-operation reset discards in-flight words; no write is emitted after release.
- pause = out_almost_full | out_full. While paused: vc0_rd=vc1_rd=0; state and cnt hold.
- States SERVE0 and SERVE1 (cur = VC being served, Wcur = its weight). Each unpaused cycle:
  - cur not empty and cnt<Wcur -> pop cur; cnt++.
  - else other VC not empty -> pop other; state switches to it; cnt=1.
  - else cur not empty -> pop cur; cnt saturates at Wcur.
  - else -> no pop; state and cnt hold.
- At most one of vc0_rd/vc1_rd is high per cycle. rd is never asserted when the corresponding empty flag is high.
- Pipeline for a pop in cycle N:
  - edge ending N: pend_q<=1, sel_q<=VC id.
  - edge ending N+1: out_data<=selected vcX_data_in, out_wr<=pend_q.
  - out_wr is high during cycle N+2 for exactly one cycle per pop.
- Latency: 2 cycles from rd to out_wr. Back-to-back pops yield back-to-back writes. Per-VC order is preserved.
- In-flight depth is 2. The downstream almost-full threshold must leave at least 2 free entries. Writes already in flight complete even if out_full rises.
- idle = vc0_empty & vc1_empty & ~pend_q & ~out_wr (combinational).
- cnt is CNT_W bits; W0/W1 are compared directly. W=0 is illegal; behaviour is undefined.

Optional Feature:
- Macro: VC_ARB_STRICT_PRIO_EN.
- Defined: strict priority. VC0 is popped whenever non-empty and not paused; VC1 is popped only when VC0 is empty. W0/W1 are ignored, cnt is held at 0, and state records the last VC served. The pipeline, pause and reset behaviour are unchanged.
- Undefined: weighted round-robin as specified above.

Test Plan:
1. Reset held with vc0_empty=0 -> vc0_rd=vc1_rd=0, out_wr=0, out_data=0. Deassert with both FIFOs empty -> idle=1.
2. VC0 holds 0A,0B,0C,0D; VC1 empty; no pause -> vc0_rd high for 4 consecutive cycles. out_wr high for 4 cycles starting 2 cycles after the first rd, with out_data 0A,0B,0C,0D. Then idle=1.
3. VC0 holds 8 words, VC1 holds 2 words, W0=3, W1=1 -> pop order VC0,VC0,VC0,VC1,VC0,VC0,VC0,VC1,VC0,VC0 with no idle cycles.
4. Stream from VC0; out_almost_full rises after the 2nd write -> rd drops in the same cycle, at most 2 further out_wr. Release -> resumes with the next word, no loss or duplication, state and cnt unchanged across the pause.
5. SERVE0 with cnt=1 and VC0 going empty while VC1 is non-empty -> next pop is VC1, state=SERVE1, cnt=1.
6. Reset asserted 1 cycle after a pop -> out_wr never asserts for that word. After release, the first out_wr carries the next popped word. With VC_ARB_STRICT_PRIO_EN defined and the stimulus of test 3 -> all 8 VC0 words precede both VC1 words.
